// File: rtl/aes_ctr_update.sv
// aes_ctr_update: multi-block AES-CTR keystream generator for the DRBG update path,
// issuing consecutive counter blocks through one shared iterative AES-128 core.

module aes_cipher_top (
   input  logic         clk,
   input  logic         rstn,
   input  logic         ld,
   output logic         done,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic [127:0] text_out
);
   logic [127:0] st, rk, nk, sr, mc, rnd_out;
   logic [31:0]  kt;
   logic [7:0]   rcon;
   logic [3:0]   rnd;
   logic         act;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box as field inverse (a^254, zero maps to zero) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r, p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   assign kt = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
   assign nk[127:96] = rk[127:96] ^ kt;
   assign nk[95:64]  = rk[95:64] ^ nk[127:96];
   assign nk[63:32]  = rk[63:32] ^ nk[95:64];
   assign nk[31:0]   = rk[31:0] ^ nk[63:32];

   // SubBytes and ShiftRows fused: byte (col c,row r) takes byte of column c+r
   always_comb begin
      sr = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127-8*(4*c+r) -: 8] = sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
      mc = {mixcol(sr[127:96]), mixcol(sr[95:64]), mixcol(sr[63:32]), mixcol(sr[31:0])};
      rnd_out = ((rnd == 4'd10) ? sr : mc) ^ nk;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st <= '0; rk <= '0; rcon <= '0; rnd <= '0; act <= 1'b0; done <= 1'b0;
      end else if (ld) begin
         st <= text_in ^ key; rk <= key; rcon <= 8'h01; rnd <= 4'd1; act <= 1'b1; done <= 1'b0;
      end else if (act) begin
         st <= rnd_out; rk <= nk; rcon <= xt(rcon); rnd <= rnd + 4'd1;
         act <= rnd != 4'd10;
         done <= rnd == 4'd10;
      end else begin
         done <= 1'b0;
      end
   end

   assign text_out = st;
endmodule

module aes_ctr_update #(
   parameter int NBLK  = 3,
   parameter int CTR_W = 128,
   parameter int NW    = $clog2(NBLK + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NW-1:0]      nblk_req,
   input  logic [127:0]       key,
   input  logic [127:0]       text_in,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               out_vld,
   output logic [128*NBLK-1:0] text_out,
   output logic [127:0]       ctr_out
);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;
   localparam logic [127:0] CMASK = {128{1'b1}} >> (128 - CTR_W);
   state_t        state, state_nxt;
   logic [127:0]  key_r, ctr, ctr_inc, core_out;
   logic [NW-1:0] n, idx, n_req;
   logic          ld, core_done, core_rstn, last;

   assign ctr_inc   = (ctr & ~CMASK) | ((ctr + 128'd1) & CMASK);
   assign n_req     = (nblk_req == '0) ? NW'(1) : (nblk_req > NW'(NBLK)) ? NW'(NBLK) : nblk_req;
   assign last      = idx == n - NW'(1);
   assign core_rstn = ~rst;

   aes_cipher_top u_aes (
      .clk      (clk),
      .rstn     (core_rstn),
      .ld       (ld),
      .done     (core_done),
      .key      (key_r),
      .text_in  (ctr),
      .text_out (core_out)
   );

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nxt;

   always_comb
      state_nxt = (state == IDLE) ? (start ? LOAD : IDLE)
                : abort           ? IDLE
                : (state == LOAD) ? WAIT
                : (state == WAIT) ? (core_done ? (last ? FIN : LOAD) : WAIT)
                : IDLE;

   always_comb begin
      ld   = state == LOAD;
      busy = state != IDLE;
   end

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (rst) begin
         key_r <= '0; ctr <= '0; n <= '0; idx <= '0;
         text_out <= '0; ctr_out <= '0; out_vld <= 1'b0;
      end else if (state == IDLE && start) begin
         key_r <= key; ctr <= text_in; n <= n_req; idx <= '0;
         text_out <= '0; out_vld <= 1'b0;
      end else if (state != IDLE && abort) begin
         idx <= '0; text_out <= '0; out_vld <= 1'b0;
      end else if (state == WAIT && core_done) begin
         for (int k = 0; k < NBLK; k++)
            if (idx == NW'(k)) text_out[128*k +: 128] <= core_out;
         if (last) begin
            done <= 1'b1; out_vld <= 1'b1; ctr_out <= ctr_inc;
         end else begin
            idx <= idx + NW'(1); ctr <= ctr_inc;
         end
      end
   end
endmodule

// File: tb/tb_aes_ctr_update.sv
// tb_aes_ctr_update: two instances (NBLK=3/CTR_W=128 and NBLK=2/CTR_W=32) share stimulus;
// expected responses are queued per instance and checked by a monitor on each done pulse.
module tb_aes_ctr_update;
   localparam int L = 11;
   localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_V  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   typedef struct {
      logic [383:0] t;
      logic [127:0] c;
      longint       cyc;
      int           n;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [1:0]   nblk_req = '0;
   logic [127:0] key = '0, text_in = '0;
   logic         busy_a, done_a, vld_a, busy_b, done_b, vld_b;
   logic [383:0] tout_a;
   logic [255:0] tout_b;
   logic [127:0] ctr_a, ctr_b;
   int           cmp = 0, fail = 0, ndone = 0;
   longint       cyc = 0;
   logic [7:0]   sb [256];
   exp_t         qa[$], qb[$];
   exp_t         ea, eb;

   aes_ctr_update #(.NBLK(3), .CTR_W(128)) dut_a (
      .clk(clk), .rst(rst), .start(start), .nblk_req(nblk_req), .key(key), .text_in(text_in),
      .abort(abort), .busy(busy_a), .done(done_a), .out_vld(vld_a), .text_out(tout_a), .ctr_out(ctr_a));

   aes_ctr_update #(.NBLK(2), .CTR_W(32)) dut_b (
      .clk(clk), .rst(rst), .start(start), .nblk_req(nblk_req), .key(key), .text_in(text_in),
      .abort(abort), .busy(busy_b), .done(done_b), .out_vld(vld_b), .text_out(tout_b), .ctr_out(ctr_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] aes(input logic [127:0] k, input logic [127:0] p);
      logic [7:0] w [176];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] r;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         w[i] = k[127-8*i -: 8];
         s[i] = p[127-8*i -: 8] ^ w[i];
      end
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
         if (i % 16 == 0) begin
            tmp[0] = sb[w[i-3]] ^ rc; tmp[1] = sb[w[i-2]]; tmp[2] = sb[w[i-1]]; tmp[3] = sb[w[i-4]];
            rc = xt(rc);
         end
         for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
      end
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
         if (rd < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rd+i];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [127:0] ctr_add(input logic [127:0] v, input int b, input int w);
      logic [127:0] m;
      m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      return (v & ~m) | ((v + 128'(b)) & m);
   endfunction

   function automatic exp_t model(input int nb, input int w, input logic [127:0] k,
                                  input logic [127:0] v, input int nr);
      exp_t e;
      e.n = (nr == 0) ? 1 : (nr > nb) ? nb : nr;
      e.t = '0;
      for (int b = 0; b < e.n; b++) e.t[128*b +: 128] = aes(k, ctr_add(v, b, w));
      e.c = ctr_add(v, e.n, w);
      e.cyc = 0;
      return e;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      cmp++;
      if (act !== exp) begin
         fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_resp(input string d, input exp_t e, input logic [383:0] t,
                           input logic [127:0] c, input logic v);
      chk({d, " text_out"}, t, e.t);
      chk({d, " ctr_out"}, {256'b0, c}, {256'b0, e.c});
      chk({d, " out_vld"}, 384'(v), 384'(1));
      chk({d, " latency"}, 384'(cyc - e.cyc), 384'(e.n * (L + 1) + 1));
   endtask

   always @(negedge clk) if (!rst) begin
      if (done_a) begin
         ndone++;
         if (qa.size() == 0) begin
            cmp++; fail++;
            $display("FAIL a unexpected done at cycle %0d", cyc);
         end else begin
            ea = qa.pop_front();
            chk_resp("a", ea, tout_a, ctr_a, vld_a);
         end
      end
      if (done_b) begin
         if (qb.size() == 0) begin
            cmp++; fail++;
            $display("FAIL b unexpected done at cycle %0d", cyc);
         end else begin
            eb = qb.pop_front();
            chk_resp("b", eb, {128'b0, tout_b}, ctr_b, vld_b);
         end
      end
   end

   task automatic check_idle(input string nm, input logic with_ctr);
      chk({nm, " busy"}, 384'({busy_a, busy_b}), '0);
      chk({nm, " done"}, 384'({done_a, done_b}), '0);
      chk({nm, " out_vld"}, 384'({vld_a, vld_b}), '0);
      chk({nm, " text_out"}, tout_a | {128'b0, tout_b}, '0);
      if (with_ctr) chk({nm, " ctr_out"}, {256'b0, ctr_a | ctr_b}, '0);
   endtask

   task automatic issue(input logic [127:0] k, input logic [127:0] v, input int nr,
                        input logic fips, input int hold);
      exp_t xa, xb;
      @(posedge clk); #1;
      start = 1'b1; key = k; text_in = v; nblk_req = 2'(nr);
      xa = model(3, 128, k, v, nr);
      xb = model(2, 32, k, v, nr);
      if (fips) begin
         xa.t = {256'b0, FIPS_CT};
         xb.t = {256'b0, FIPS_CT};
      end
      xa.cyc = cyc; xb.cyc = cyc;
      qa.push_back(xa); qb.push_back(xb);
      @(posedge clk); #1;
      chk("busy after start", 384'({busy_a, busy_b}), 384'(3));
      for (int i = 0; i < hold; i++) begin
         key = rnd128(); text_in = rnd128(); nblk_req = 2'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0; key = rnd128(); text_in = rnd128(); nblk_req = 2'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!busy_a && !busy_b) return;
      end
      cmp++; fail++;
      $display("FAIL idle timeout: busy_a=%0b busy_b=%0b", busy_a, busy_b);
   endtask

   initial begin
      logic [7:0] g, inv;
      logic [7:0] ex [256];
      int lg [256];
      int d0;
      logic [127:0] v;
      g = 8'h01;
      for (int i = 0; i < 255; i++) begin
         ex[i] = g; lg[g] = i; g = g ^ xt(g);
      end
      for (int a = 0; a < 256; a++) begin
         inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
         for (int b = 0; b < 8; b++)
            sb[a][b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ ((8'h63 >> b) & 8'h01) != 0;
      end

      repeat (3) @(posedge clk);
      #1 check_idle("reset", 1'b1);
      rst = 1'b0;

      issue(FIPS_K, FIPS_V, 1, 1'b1, 0); wait_idle();
      issue(rnd128(), 128'd0, 3, 1'b0, 0); wait_idle();
      issue(rnd128(), 128'h0123456789abcdef01234567ffffffff, 2, 1'b0, 0); wait_idle();
      issue(rnd128(), rnd128(), 0, 1'b0, 0); wait_idle();
      issue(rnd128(), rnd128(), 3, 1'b0, 0); wait_idle();

      // abort during the second block's wait, then restart one cycle later
      issue(rnd128(), rnd128(), 3, 1'b0, 0);
      repeat (14) @(posedge clk);
      #1 abort = 1'b1;
      void'(qa.pop_back()); void'(qb.pop_back());
      @(posedge clk); #1;
      abort = 1'b0;
      check_idle("abort", 1'b0);
      issue(rnd128(), 128'd5, 1, 1'b0, 0); wait_idle();

      d0 = ndone;
      issue(rnd128(), rnd128(), 2, 1'b0, 24); wait_idle();
      repeat (3) @(posedge clk);
      chk("single done under repeated start", 384'(ndone - d0), 384'(1));

      issue(rnd128(), rnd128(), 3, 1'b0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      void'(qa.pop_back()); void'(qb.pop_back());
      @(posedge clk); #1;
      check_idle("rst mid-wait", 1'b1);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         v = rnd128();
         if ($urandom_range(0, 1) == 1) v[31:0] = 32'hffffffff - $urandom_range(0, 2);
         issue(rnd128(), v, $urandom_range(0, 3), 1'b0, 0);
         wait_idle();
      end

      repeat (4) @(posedge clk);
      chk("queue a drained", 384'(qa.size()), '0);
      chk("queue b drained", 384'(qb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
      $finish;
   end
endmodule
